fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It sits directly upstream of the decode stage and the control unit. It owns the program counter and issues requests to instruction memory over a ready handshake, then delivers instructions through the IF/ID pipeline register. It consumes the execute-stage redirect (`PCSrcE`, `PCJalSrcE`, targets) and the hazard unit's `StallF`/`StallD`/`FlushD`.

---
 rtl/fetch_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the RV32I pipeline.
// Owns PCF, issues ready-handshake requests to instruction memory, and
// drives the IF/ID pipeline register. Optional performance counters are
// compiled in when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic        PCJalSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchWaitF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pcf_q, pcf_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   redir_q, redir_d;
  logic              imem_req_q, imem_req_d;
  logic [XLEN-1:0]   if_instr_q, if_instr_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [XLEN-1:0]   if_pc4_q, if_pc4_d;
  logic              if_valid_q, if_valid_d;

  logic              deliver;
  logic [XLEN-1:0]   dl_instr;
  logic [XLEN-1:0]   dl_pc;
  logic [XLEN-1:0]   redirect_target;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0]   bubble_cnt_q, bubble_cnt_d;
`endif

  // JALR targets have their LSB forced to zero
  assign redirect_target = PCJalSrcE ? (ALUResultE & ~XLEN'(1)) : PCTargetE;

  // Fetch FSM, PC update and skid/redirect capture
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    redir_d      = redir_q;
    deliver      = 1'b0;
    dl_instr     = imem_rdata;
    dl_pc        = pcf_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (PCSrcE) begin
          if (imem_ready) begin
            pcf_d = redirect_target;
          end else begin
            redir_d = redirect_target;
            state_d = ST_DROP;
          end
        end else if (imem_ready) begin
          if (StallF) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pcf_q;
            state_d      = ST_HOLD;
          end else begin
            deliver = 1'b1;
            pcf_d   = pcf_q + XLEN'(4);
          end
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          pcf_d   = redirect_target;
          state_d = ST_FETCH;
        end else if (!StallF) begin
          deliver  = 1'b1;
          dl_instr = skid_instr_q;
          dl_pc    = skid_pc_q;
          pcf_d    = pcf_q + XLEN'(4);
          state_d  = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (PCSrcE) begin
          redir_d = redirect_target;
        end
        if (imem_ready) begin
          pcf_d   = PCSrcE ? redirect_target : redir_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    imem_req_d = (state_d == ST_FETCH) || (state_d == ST_DROP);
  end

  // IF/ID register next-state: hold on StallD, bubble on flush or no delivery
  always_comb begin
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_valid_d = if_valid_q;
    if (!StallD) begin
      if (FlushD || !deliver) begin
        if_instr_d = NOP_INSTR;
        if_pc_d    = '0;
        if_pc4_d   = '0;
        if_valid_d = 1'b0;
      end else begin
        if_instr_d = dl_instr;
        if_pc_d    = dl_pc;
        if_pc4_d   = dl_pc + XLEN'(4);
        if_valid_d = 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Count valid loads and bubble loads into IF/ID
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!StallD) begin
      if (if_valid_d) begin
        fetch_cnt_d = fetch_cnt_q + XLEN'(1);
      end else begin
        bubble_cnt_d = bubble_cnt_q + XLEN'(1);
      end
    end
  end
`endif

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pcf_q        <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      redir_q      <= '0;
      imem_req_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      if_pc4_q     <= '0;
      if_valid_q   <= 1'b0;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      redir_q      <= redir_d;
      imem_req_q   <= imem_req_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pc4_q     <= if_pc4_d;
      if_valid_q   <= if_valid_d;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
`endif
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pcf_q;
  assign InstrD     = if_instr_q;
  assign PCD        = if_pc_q;
  assign PCPlus4D   = if_pc4_q;
  assign ValidD     = if_valid_q;
  assign FetchWaitF = imem_req_q & ~imem_ready;
`ifdef FETCH_PERF_EN
  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory echoes the address as the
// instruction word, expected deliveries are queued by the stimulus and
// popped by a monitor whenever IF/ID loads a valid instruction.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD;
  logic        PCSrcE, PCJalSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchWaitF;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic load_seen = 1'b0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCJalSrcE  (PCJalSrcE),
    .PCTargetE  (PCTargetE),
    .ALUResultE (ALUResultE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchWaitF (FetchWaitF)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount (FetchCount),
    .BubbleCount(BubbleCount)
`endif
  );

  // Memory returns its address as the instruction word
  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.instr = pc;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCJalSrcE = 1'b0;
    PCTargetE = 32'h0; ALUResultE = 32'h0;
  endtask

  // Record whether IF/ID is loaded on this edge
  always @(posedge clk) load_seen <= reset && !StallD;

  // Monitor: each valid IF/ID load must match the oldest expected delivery
  always @(negedge clk) begin
    if (load_seen && ValidD) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got PCD=0x%08h InstrD=0x%08h expected none", PCD, InstrD);
      end else begin
        e = exp_q.pop_front();
        chk("sb_InstrD", InstrD, e.instr);
        chk("sb_PCD", PCD, e.pc);
        chk("sb_PCPlus4D", PCPlus4D, e.pc4);
      end
    end
  end

  initial begin
`ifdef FETCH_PERF_EN
    logic [31:0] bub0, fet0;
`endif
    reset = 1'b0;
    imem_ready = 1'b0;
    quiet();
    tick();
    tick();

    // Reset state
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_InstrD", InstrD, 32'h0000_0013);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_ValidD", 32'(ValidD), 32'd0);
    chk("rst_FetchWaitF", 32'(FetchWaitF), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_FetchCount", FetchCount, 32'h0);
    chk("rst_BubbleCount", BubbleCount, 32'h0);
`endif

    // Release reset: first request one cycle later
    reset = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Zero-wait streaming 0,4
    imem_ready = 1'b1;
    push(32'h0);
    tick();
    chk("stream_addr4", imem_addr, 32'h4);
    push(32'h4);
    tick();
    chk("stream_addr8", imem_addr, 32'h8);

    // Three wait cycles at PC 8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_FetchWaitF", 32'(FetchWaitF), 32'd1);
      tick();
      chk("wait_addr_held", imem_addr, 32'h8);
      chk("wait_bubble", 32'(ValidD), 32'd0);
    end
    imem_ready = 1'b1;
    #1;
    chk("wait_done_FetchWaitF", 32'(FetchWaitF), 32'd0);
    push(32'h8);
    tick();
    chk("after_wait_addr", imem_addr, 32'hC);
    push(32'hC);
    tick();
    chk("pre_hold_addr", imem_addr, 32'h10);

    // Stall two cycles while ready at 0x10
    StallF = 1'b1; StallD = 1'b1;
    tick();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_PCD_frozen", PCD, 32'hC);
    imem_ready = 1'b0;
    tick();
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_PCD_frozen2", PCD, 32'hC);
    chk("hold_ValidD", 32'(ValidD), 32'd1);
    StallF = 1'b0; StallD = 1'b0;
    push(32'h10);
    tick();
    chk("hold_release_PCD", PCD, 32'h10);
    chk("hold_release_addr", imem_addr, 32'h14);
    chk("hold_release_req", 32'(imem_req), 32'd1);

    // Stream up to 0x20
    imem_ready = 1'b1;
    push(32'h14); tick();
    push(32'h18); tick();
    push(32'h1C); tick();
    chk("pre_drop_addr", imem_addr, 32'h20);

    // JALR redirect to 0x101 while waiting at 0x20
    imem_ready = 1'b0;
    PCSrcE = 1'b1; PCJalSrcE = 1'b1;
    ALUResultE = 32'h0000_0101; PCTargetE = 32'hDEAD_0000;
    tick();
    quiet();
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr_stable", imem_addr, 32'h20);
    #1;
    chk("drop_FetchWaitF", 32'(FetchWaitF), 32'd1);
    tick();
    chk("drop_addr_stable2", imem_addr, 32'h20);
    imem_ready = 1'b1;
    tick();
    chk("drop_target_addr", imem_addr, 32'h100);
    chk("drop_no_delivery", 32'(ValidD), 32'd0);
    push(32'h100);
    tick();
    chk("after_drop_addr", imem_addr, 32'h104);

    // Flush over a valid delivery
`ifdef FETCH_PERF_EN
    bub0 = BubbleCount;
    fet0 = FetchCount;
`endif
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    chk("flush_InstrD", InstrD, 32'h0000_0013);
    chk("flush_ValidD", 32'(ValidD), 32'd0);
    chk("flush_PCD", PCD, 32'h0);
    chk("flush_pc_advanced", imem_addr, 32'h108);
`ifdef FETCH_PERF_EN
    chk("flush_BubbleCount", BubbleCount, bub0 + 32'd1);
    chk("flush_FetchCount", FetchCount, fet0);
`endif

    // Branch redirect to the top of the address space, then wrap
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    quiet();
    chk("wrap_target_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_PCPlus4D", PCPlus4D, 32'h0);
    chk("wrap_PCD", PCD, 32'hFFFF_FFFC);

    // Reset while in DROP
    imem_ready = 1'b0;
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    quiet();
    chk("pre_reset_drop_req", 32'(imem_req), 32'd1);
    reset = 1'b0;
    tick();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_ValidD", 32'(ValidD), 32'd0);
    chk("midrst_InstrD", InstrD, 32'h0000_0013);
    reset = 1'b1;
    tick();
    chk("midrst_restart_req", 32'(imem_req), 32'd1);
    chk("midrst_restart_addr", imem_addr, 32'h0);
    tick();
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
